// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU, PC+4 or extended load data and drives a single
// register-file write port, with a bounded wait for load data.
module writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  rd,
    input  logic        reg_write_en,
    input  logic [1:0]  result_src,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        regWrite,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        load_error,
    output logic [1:0]  dbg_state
);

    // Handshake: an instruction transfers on a rising edge with wb_valid && wb_ready;
    // wb_ready is high only in S_IDLE and upstream holds wb_valid until the transfer.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;
    logic        regwrite_q, regwrite_d;
    logic        load_error_q, load_error_d;

    logic        load_ok;
    logic        expire;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        case (funct3)
            F3_LB, F3_LBU: load_ok = 1'b1;
            F3_LH, F3_LHU: load_ok = ~alu_result[0];
            F3_LW:         load_ok = (alu_result[1:0] == 2'b00);
            default:       load_ok = 1'b0;
        endcase
    end

    // The counter value after this cycle's increment is what reaches the limit.
    assign expire = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_val = {24'd0, byte_sel};
            F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_val = {16'd0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        regwrite_d   = 1'b0;
        load_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    rd_d     = rd;
                    we_d     = reg_write_en;
                    funct3_d = funct3;
                    off_d    = alu_result[1:0];
                    cnt_d    = 16'd0;
                    case (result_src)
                        2'b00, 2'b10: begin
                            state_d    = S_WRITE;
                            rf_addr_d  = rd;
                            rf_data_d  = (result_src == 2'b00) ? alu_result : pc_plus4;
                            regwrite_d = reg_write_en && (rd != 5'd0);
                        end
                        2'b01: begin
                            if (load_ok) state_d = S_WAIT_MEM;
                            else         load_error_d = 1'b1;
                        end
                        default: load_error_d = 1'b1;
                    endcase
                end
            end
            S_WAIT_MEM: begin
                // Data arriving on the expiry cycle still completes the load.
                if (mem_rvalid) begin
                    state_d    = S_WRITE;
                    rf_addr_d  = rd_q;
                    rf_data_d  = load_val;
                    regwrite_d = we_q && (rd_q != 5'd0);
                end else if (expire) begin
                    state_d      = S_IDLE;
                    cnt_d        = 16'd0;
                    load_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_q         <= 5'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            cnt_q        <= 16'd0;
            rf_addr_q    <= 5'd0;
            rf_data_q    <= 32'd0;
            regwrite_q   <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            regwrite_q   <= regwrite_d;
            load_error_q <= load_error_d;
        end
    end

    assign wb_ready   = (state_q == S_IDLE);
    assign regWrite   = regwrite_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign load_error = load_error_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit against a behavioural model of the
// writeback rules; timeout limit shortened to 4 cycles.
module tb_writeback_unit;

    localparam int TO = 4;
    localparam int K_WRITE = 0;
    localparam int K_ERR   = 1;
    localparam int K_LOAD  = 2;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  rd;
    logic        reg_write_en;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        regWrite;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        load_error;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_data;
    logic [4:0]  last_addr;

    writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .rd(rd), .reg_write_en(reg_write_en), .result_src(result_src),
        .funct3(funct3), .alu_result(alu_result), .pc_plus4(pc_plus4),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .regWrite(regWrite),
        .rf_addr(rf_addr), .rf_data(rf_data), .load_error(load_error),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: outcome of one instruction from the architectural rules.
    function automatic void predict(input logic [1:0] src, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] pc,
                                    input logic [31:0] rdata,
                                    output int kind, output logic [31:0] val);
        int unsigned off;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        bit legal;
        off = addr % 4;
        w = rdata >> (8 * off);
        b = w & 32'hFF;
        h = w & 32'hFFFF;
        kind = K_WRITE;
        val = 32'd0;
        if (src == 2'd0) val = addr;
        else if (src == 2'd2) val = pc;
        else if (src == 2'd3) kind = K_ERR;
        else begin
            case (f3)
                3'd0, 3'd4: legal = 1'b1;
                3'd1, 3'd5: legal = (off % 2) == 0;
                3'd2:       legal = off == 0;
                default:    legal = 1'b0;
            endcase
            if (!legal) kind = K_ERR;
            else begin
                kind = K_LOAD;
                case (f3)
                    3'd0:    val = (b > 127) ? b - 32'd256 : b;
                    3'd4:    val = b;
                    3'd1:    val = (h > 32767) ? h - 32'd65536 : h;
                    3'd5:    val = h;
                    default: val = rdata;
                endcase
            end
        end
    endfunction

    task automatic check_write(input logic [4:0] i_rd, input logic i_we);
        logic [31:0] v;
        v = exp_q.pop_front();
        @(negedge clk);
        check("wr_regwrite", regWrite, i_we && (i_rd != 0));
        check("wr_addr", rf_addr, i_rd);
        check("wr_data", rf_data, v);
        check("wr_ready", wb_ready, 0);
        check("wr_err", load_error, 0);
        last_data = v;
        last_addr = i_rd;
        @(posedge clk); #1;
        check("post_regwrite", regWrite, 0);
        check("post_ready", wb_ready, 1);
        check("post_hold", rf_data, last_data);
    endtask

    task automatic check_error();
        @(negedge clk);
        check("err_pulse", load_error, 1);
        check("err_nowrite", regWrite, 0);
        check("err_ready", wb_ready, 1);
        check("err_hold", rf_data, last_data);
        @(posedge clk); #1;
        check("err_pulse_end", load_error, 0);
    endtask

    // driver: present one instruction, then follow it to completion
    task automatic run_instr(input logic [4:0] i_rd, input logic i_we, input logic [1:0] i_src,
                             input logic [2:0] i_f3, input logic [31:0] i_addr,
                             input logic [31:0] i_pc, input logic [31:0] i_rdata, input int i_delay);
        int kind;
        logic [31:0] val;
        int cycles;
        bit timed_out;
        predict(i_src, i_f3, i_addr, i_pc, i_rdata, kind, val);
        check("ready_idle", wb_ready, 1);
        wb_valid = 1'b1; rd = i_rd; reg_write_en = i_we; result_src = i_src;
        funct3 = i_f3; alu_result = i_addr; pc_plus4 = i_pc;
        @(posedge clk); #1;
        wb_valid = 1'b0; rd = 5'($urandom); reg_write_en = 1'($urandom);
        result_src = 2'($urandom); funct3 = 3'($urandom);
        alu_result = $urandom; pc_plus4 = $urandom;
        if (kind == K_ERR) begin
            check_error();
        end else if (kind == K_WRITE) begin
            exp_q.push_back(val);
            check_write(i_rd, i_we);
        end else begin
            timed_out = (i_delay >= TO);
            cycles = timed_out ? TO : i_delay + 1;
            for (int k = 1; k <= cycles; k++) begin
                mem_rvalid = (k == i_delay + 1);
                mem_rdata = mem_rvalid ? i_rdata : $urandom;
                @(negedge clk);
                check("wait_ready", wb_ready, 0);
                check("wait_regwrite", regWrite, 0);
                check("wait_err", load_error, 0);
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata = $urandom;
            end
            if (timed_out) begin
                check_error();
                mem_rvalid = 1'b1;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                @(negedge clk);
                check("late_rvalid_ignored", regWrite, 0);
                check("late_ready", wb_ready, 1);
                @(posedge clk); #1;
            end else begin
                exp_q.push_back(val);
                check_write(i_rd, i_we);
            end
        end
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; rd = '0; reg_write_en = 1'b0; result_src = '0;
        funct3 = '0; alu_result = '0; pc_plus4 = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        last_data = '0; last_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_regwrite", regWrite, 0);
        check("rst_err", load_error, 0);
        check("rst_addr", rf_addr, 0);
        check("rst_data", rf_data, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // directed cases
        run_instr(5'd5, 1'b1, 2'b00, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
        run_instr(5'd7, 1'b1, 2'b01, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3);
        run_instr(5'd8, 1'b1, 2'b01, 3'd4, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3);
        run_instr(5'd9, 1'b1, 2'b01, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        run_instr(5'd9, 1'b1, 2'b01, 3'd2, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
        run_instr(5'd10, 1'b1, 2'b01, 3'd2, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 10);
        run_instr(5'd0, 1'b1, 2'b10, 3'd0, 32'h0, 32'h0000_0040, 32'h0, 0);
        run_instr(5'd11, 1'b1, 2'b11, 3'd0, 32'h0, 32'h0, 32'h0, 0);
        run_instr(5'd12, 1'b1, 2'b01, 3'd2, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, TO - 1);
        run_instr(5'd13, 1'b1, 2'b01, 3'd5, 32'h0000_4002, 32'h0, 32'h9ABC_0001, 0);

        // random traffic
        for (int i = 0; i < 120; i++) begin
            run_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      $urandom, $urandom, $urandom, $urandom_range(0, 5));
        end

        // reset while waiting for load data, with data arriving during reset
        check("mid_ready_idle", wb_ready, 1);
        wb_valid = 1'b1; rd = 5'd3; reg_write_en = 1'b1; result_src = 2'b01;
        funct3 = 3'd2; alu_result = 32'h0000_5000;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        check("mid_waiting", wb_ready, 0);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        #1;
        check("mid_async_data", rf_data, 0);
        check("mid_async_addr", rf_addr, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; reset = 1'b0;
        last_data = '0; last_addr = '0;
        @(negedge clk);
        check("mid_regwrite", regWrite, 0);
        check("mid_data", rf_data, 0);
        check("mid_ready", wb_ready, 1);
        @(posedge clk); #1;
        run_instr(5'd4, 1'b1, 2'b00, 3'd0, 32'hA5A5_0F0F, 32'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
